// File: rtl/menu_nav_ctrl.sv
// Menu navigation controller for the on-screen overlay.
// Debounces the five push-buttons, turns debounced rising edges into
// single-cycle press events and runs the CLOSED / MAIN / COLOR menu FSM
// that drives the overlay configuration and the committed waveform mode.
module menu_nav_ctrl #(
    parameter int DEBOUNCE   = 4,
    parameter int TIMEOUT    = 1000,
    parameter int NUM_GRAPHS = 20
) (
    input  logic       slow_clock,
    input  logic       reset_n,
    input  logic       btn_c,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [1:0] toggle_menu,
    output logic [1:0] select_wave,
    output logic [1:0] select_color,
    output logic [4:0] GRAPH_STATE,
    output logic       left,
    output logic       right,
    output logic [1:0] wave_mode
);

    localparam int DB_W   = $clog2(DEBOUNCE) + 1;
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
    localparam logic [4:0]        GRAPH_LAST = 5'(NUM_GRAPHS - 1);

    // Button bit positions; a lower index has higher priority.
    localparam int B_C = 0;
    localparam int B_U = 1;
    localparam int B_D = 2;
    localparam int B_L = 3;
    localparam int B_R = 4;

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        MAIN   = 2'd1,
        COLOR  = 2'd2
    } state_t;

    logic [4:0]      btn_raw;
    logic [DB_W-1:0] db_cnt [5];
    logic [4:0]      btn_deb;
    logic [4:0]      btn_deb_d;
    logic [4:0]      press;
    logic            accept;

    state_t          state,      state_nxt;
    logic [1:0]      sel_wave,   sel_wave_nxt;
    logic [1:0]      sel_color,  sel_color_nxt;
    logic [4:0]      graph,      graph_nxt;
    logic [1:0]      mode,       mode_nxt;
    logic            left_q,     left_nxt;
    logic            right_q,    right_nxt;
    logic [IDLE_W-1:0] idle,     idle_nxt;

    assign btn_raw = {btn_r, btn_l, btn_d, btn_u, btn_c};

    // Per-button debounce: the level flips only after DEBOUNCE consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge slow_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
            end
            btn_deb   <= '0;
            btn_deb_d <= '0;
        end else begin
            btn_deb_d <= btn_deb;
            for (int i = 0; i < 5; i++) begin
                if (btn_raw[i] == btn_deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_deb[i] <= ~btn_deb[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A press is the first cycle of a debounced high level; releases and
    // held levels produce nothing.
    assign press  = btn_deb & ~btn_deb_d;
    assign accept = |press;

    // Menu state and every overlay output are registered here.
    always_ff @(posedge slow_clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLOSED;
            sel_wave  <= '0;
            sel_color <= '0;
            graph     <= '0;
            mode      <= '0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            idle      <= '0;
        end else begin
            state     <= state_nxt;
            sel_wave  <= sel_wave_nxt;
            sel_color <= sel_color_nxt;
            graph     <= graph_nxt;
            mode      <= mode_nxt;
            left_q    <= left_nxt;
            right_q   <= right_nxt;
            idle      <= idle_nxt;
        end
    end

    // Next-state logic: acts on the single highest-priority press (c>u>d>l>r)
    // and closes an idle menu once the timeout expires without a press.
    always_comb begin
        state_nxt     = state;
        sel_wave_nxt  = sel_wave;
        sel_color_nxt = sel_color;
        graph_nxt     = graph;
        mode_nxt      = mode;
        left_nxt      = 1'b0;
        right_nxt     = 1'b0;
        idle_nxt      = (state == CLOSED) ? '0 : idle + IDLE_W'(1);

        if (accept) begin
            idle_nxt = '0;
        end

        case (state)
            CLOSED: begin
                if (press[B_C]) begin
                    state_nxt    = MAIN;
                    sel_wave_nxt = 2'd0;
                end
            end
            MAIN: begin
                if (press[B_C]) begin
                    if (sel_wave == 2'd3) begin
                        state_nxt     = COLOR;
                        sel_color_nxt = 2'd0;
                    end else begin
                        mode_nxt  = sel_wave;
                        state_nxt = CLOSED;
                    end
                end else if (press[B_U]) begin
                    sel_wave_nxt = sel_wave - 2'd1;
                end else if (press[B_D]) begin
                    sel_wave_nxt = sel_wave + 2'd1;
                end else if (press[B_L]) begin
                    if (sel_wave == 2'd3) begin
                        graph_nxt = (graph == 5'd0) ? GRAPH_LAST : graph - 5'd1;
                    end
                end else if (press[B_R]) begin
                    if (sel_wave == 2'd3) begin
                        graph_nxt = (graph == GRAPH_LAST) ? 5'd0 : graph + 5'd1;
                    end
                end
            end
            COLOR: begin
                if (press[B_C]) begin
                    state_nxt = MAIN;
                end else if (press[B_U]) begin
                    sel_color_nxt = (sel_color == 2'd0) ? 2'd2 : sel_color - 2'd1;
                end else if (press[B_D]) begin
                    sel_color_nxt = (sel_color == 2'd2) ? 2'd0 : sel_color + 2'd1;
                end else if (press[B_L]) begin
                    left_nxt = 1'b1;
                end else if (press[B_R]) begin
                    right_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = CLOSED;
            end
        endcase

        if (!accept && (state != CLOSED) && (idle == IDLE_LAST)) begin
            state_nxt = CLOSED;
            idle_nxt  = '0;
        end
    end

    assign toggle_menu  = state;
    assign select_wave  = sel_wave;
    assign select_color = sel_color;
    assign GRAPH_STATE  = graph;
    assign wave_mode    = mode;
    assign left         = left_q;
    assign right        = right_q;

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Self-checking bench for menu_nav_ctrl: directed walk through the menu
// followed by random button activity, compared against a behavioural model
// that tracks the menu as plain integers with modulo arithmetic.
module tb_menu_nav_ctrl;

    localparam int DEBOUNCE   = 4;
    localparam int TIMEOUT    = 1000;
    localparam int NUM_GRAPHS = 20;

    localparam logic [4:0] K_C = 5'b00001;
    localparam logic [4:0] K_U = 5'b00010;
    localparam logic [4:0] K_D = 5'b00100;
    localparam logic [4:0] K_L = 5'b01000;
    localparam logic [4:0] K_R = 5'b10000;

    logic       slow_clock = 1'b0;
    logic       reset_n    = 1'b0;
    logic       btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
    logic [1:0] toggle_menu, select_wave, select_color, wave_mode;
    logic [4:0] GRAPH_STATE;
    logic       left, right;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int               m_menu, m_wave, m_color, m_graph, m_mode, m_idle;
    int               m_left, m_right;
    logic [4:0]       m_deb, m_prev;
    logic [DEBOUNCE-1:0] m_hist [5];

    menu_nav_ctrl #(
        .DEBOUNCE  (DEBOUNCE),
        .TIMEOUT   (TIMEOUT),
        .NUM_GRAPHS(NUM_GRAPHS)
    ) dut (
        .slow_clock  (slow_clock),
        .reset_n     (reset_n),
        .btn_c       (btn_c),
        .btn_u       (btn_u),
        .btn_d       (btn_d),
        .btn_l       (btn_l),
        .btn_r       (btn_r),
        .toggle_menu (toggle_menu),
        .select_wave (select_wave),
        .select_color(select_color),
        .GRAPH_STATE (GRAPH_STATE),
        .left        (left),
        .right       (right),
        .wave_mode   (wave_mode)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("toggle_menu",  32'(toggle_menu),  32'(m_menu));
        check("select_wave",  32'(select_wave),  32'(m_wave));
        check("select_color", 32'(select_color), 32'(m_color));
        check("GRAPH_STATE",  32'(GRAPH_STATE),  32'(m_graph));
        check("wave_mode",    32'(wave_mode),    32'(m_mode));
        check("left",         32'(left),         32'(m_left));
        check("right",        32'(right),        32'(m_right));
    endtask

    function automatic void model_reset();
        m_menu = 0; m_wave = 0; m_color = 0; m_graph = 0; m_mode = 0;
        m_idle = 0; m_left = 0; m_right = 0;
        m_deb = '0; m_prev = '0;
        for (int b = 0; b < 5; b++) m_hist[b] = '0;
    endfunction

    // One clock edge of the model, given the raw buttons sampled at that edge.
    function automatic void model_step(input logic [4:0] r);
        logic [4:0] ev;
        int         k;
        int         was_open;
        ev = m_deb & ~m_prev;
        k  = -1;
        for (int b = 4; b >= 0; b--) if (ev[b]) k = b;
        m_left   = 0;
        m_right  = 0;
        was_open = (m_menu != 0);
        case (m_menu)
            0: if (k == 0) begin m_menu = 1; m_wave = 0; end
            1: case (k)
                0: if (m_wave < 3) begin m_mode = m_wave; m_menu = 0; end
                   else begin m_menu = 2; m_color = 0; end
                1: m_wave = (m_wave + 3) % 4;
                2: m_wave = (m_wave + 1) % 4;
                3: if (m_wave == 3) m_graph = (m_graph + NUM_GRAPHS - 1) % NUM_GRAPHS;
                4: if (m_wave == 3) m_graph = (m_graph + 1) % NUM_GRAPHS;
                default: ;
            endcase
            default: case (k)
                0: m_menu = 1;
                1: m_color = (m_color + 2) % 3;
                2: m_color = (m_color + 1) % 3;
                3: m_left = 1;
                4: m_right = 1;
                default: ;
            endcase
        endcase
        if (!was_open || k >= 0) begin
            m_idle = 0;
        end else if (m_idle == TIMEOUT - 1) begin
            m_menu = 0;
            m_idle = 0;
        end else begin
            m_idle++;
        end
        // Debounced level follows after DEBOUNCE consecutive opposite samples.
        m_prev = m_deb;
        for (int b = 0; b < 5; b++) begin
            m_hist[b] = {m_hist[b][DEBOUNCE-2:0], r[b]};
            if (!m_deb[b] && (m_hist[b] == '1)) m_deb[b] = 1'b1;
            else if (m_deb[b] && (m_hist[b] == '0)) m_deb[b] = 1'b0;
        end
    endfunction

    task automatic drive(input logic [4:0] r);
        btn_c = r[0]; btn_u = r[1]; btn_d = r[2]; btn_l = r[3]; btn_r = r[4];
    endtask

    task automatic cycle(input logic [4:0] r);
        @(negedge slow_clock);
        check_outputs();
        drive(r);
        @(posedge slow_clock);
        model_step(r);
    endtask

    task automatic press(input logic [4:0] r);
        repeat (6) cycle(r);
        repeat (6) cycle(5'b0);
    endtask

    initial begin
        int nr;
        int nl;
        logic [4:0] rr;

        model_reset();
        #1;
        check("rst_toggle", 32'(toggle_menu), 0);
        check("rst_wave",   32'(select_wave), 0);
        check("rst_graph",  32'(GRAPH_STATE), 0);
        check("rst_mode",   32'(wave_mode),   0);
        repeat (2) @(negedge slow_clock);
        reset_n = 1'b1;
        repeat (3) cycle(5'b0);

        // Short glitch on c must not open the menu
        repeat (2) cycle(K_C);
        repeat (6) cycle(5'b0);
        #1 check("glitch_closed", 32'(toggle_menu), 0);

        // Held c opens the menu exactly DEBOUNCE+1 edges after the raw rise
        for (int i = 1; i <= 6; i++) begin
            cycle(K_C);
            #1 check("open_latency", 32'(toggle_menu), (i >= 5) ? 1 : 0);
        end
        repeat (6) cycle(5'b0);
        check("open_wave0", 32'(select_wave), 0);

        press(K_U);
        #1 check("up_wrap", 32'(select_wave), 3);
        press(K_D);
        press(K_D);
        #1 check("down_twice", 32'(select_wave), 1);
        press(K_C);
        #1 check("commit_mode", 32'(wave_mode), 1);
        check("commit_close", 32'(toggle_menu), 0);

        // Graph slot wrap on line 3
        press(K_C);
        press(K_U);
        press(K_L);
        #1 check("graph_dec_wrap", 32'(GRAPH_STATE), 19);
        press(K_R);
        #1 check("graph_inc_wrap", 32'(GRAPH_STATE), 0);
        press(K_L);
        #1 check("graph_back_19", 32'(GRAPH_STATE), 19);
        press(K_D);
        press(K_L);
        #1 check("graph_ignored", 32'(GRAPH_STATE), 19);

        // Colour editor
        press(K_U);
        press(K_C);
        #1 check("enter_color", 32'(toggle_menu), 2);
        nr = 0;
        nl = 0;
        for (int i = 0; i < 12; i++) begin
            cycle((i < 6) ? K_R : 5'b0);
            #1;
            nr += int'(right);
            nl += int'(left);
        end
        check("right_pulse_len", 32'(nr), 1);
        check("left_quiet", 32'(nl), 0);
        press(K_D);
        #1 check("color_1", 32'(select_color), 1);
        press(K_D);
        #1 check("color_2", 32'(select_color), 2);
        press(K_D);
        #1 check("color_wrap0", 32'(select_color), 0);
        press(K_C);
        #1 check("back_main", 32'(toggle_menu), 1);
        check("back_wave3", 32'(select_wave), 3);

        // Simultaneous c and u: only c acts; holding u yields no later event
        repeat (6) cycle(K_C | K_U);
        repeat (10) cycle(K_U);
        repeat (6) cycle(5'b0);
        #1 check("prio_color", 32'(toggle_menu), 2);
        check("prio_no_u", 32'(select_color), 0);
        press(K_C);

        // Idle timeout in MAIN
        repeat (TIMEOUT + 10) cycle(5'b0);
        #1 check("timeout_close", 32'(toggle_menu), 0);
        check("timeout_graph", 32'(GRAPH_STATE), 19);

        // Asynchronous reset while in COLOR
        press(K_C);
        press(K_U);
        press(K_C);
        @(negedge slow_clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_toggle", 32'(toggle_menu),  0);
        check("async_wave",   32'(select_wave),  0);
        check("async_color",  32'(select_color), 0);
        check("async_graph",  32'(GRAPH_STATE),  0);
        check("async_mode",   32'(wave_mode),    0);
        check("async_left",   32'(left),         0);
        check("async_right",  32'(right),        0);
        model_reset();
        repeat (2) @(negedge slow_clock);
        reset_n = 1'b1;

        // Random button activity, including sub-DEBOUNCE glitches
        rr = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 9) == 0) rr[b] = ~rr[b];
            end
            cycle(rr);
        end
        cycle(5'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/menu_nav_ctrl.md
Name: menu_nav_ctrl

Overview:
- Navigation controller that sequences the on-screen menu overlay from the five board push-buttons.
- Debounces the buttons, runs the menu state machine and produces the overlay's configuration signals: toggle_menu, select_wave, select_color, GRAPH_STATE and the left/right colour-step pulses.
- Also holds the committed waveform mode consumed by the audio datapath.
- Sits between the raw button pins and the menu/colour overlay renderer; runs on slow_clock.

Parameters:
- DEBOUNCE, 4, consecutive slow_clock cycles a raw button level must hold before the debounced level follows.
- TIMEOUT, 1000, slow_clock cycles with no accepted press before an open menu auto-closes.
- NUM_GRAPHS, 20, number of graph slots; GRAPH_STATE ranges 0..NUM_GRAPHS-1 (must be ≤32).

Ports:
- slow_clock  in  1  sole clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_c  in  1  raw centre button (open, select, back).
- btn_u  in  1  raw up button.
- btn_d  in  1  raw down button.
- btn_l  in  1  raw left button.
- btn_r  in  1  raw right button.
- toggle_menu  out  2  0 = overlay off, 1 = main menu, 2 = colour editor; 3 is never driven.
- select_wave  out  2  highlighted main-menu line, 0..3.
- select_color  out  2  colour channel under edit, 0..2 (R, G, B).
- GRAPH_STATE  out  5  current graph slot.
- left  out  1  one-cycle colour-decrement pulse.
- right  out  1  one-cycle colour-increment pulse.
- wave_mode  out  2  committed waveform style, 0..2.

Behaviour:
- Reset: every output is 0; FSM enters CLOSED; debounce counters, debounced levels and the idle counter are cleared. Reset may assert at any time, including mid-debounce or while in COLOR, and the block returns to this state immediately.
- Debounce:
  - One counter per button. It increments while raw ≠ debounced level and clears whenever raw = debounced level.
  - When the count reaches DEBOUNCE-1 and raw still differs, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE cycles produces no change.
- Press event: a one-cycle internal pulse on a debounced 0→1 transition. Releases generate nothing. Holding a button gives exactly one event (no auto-repeat).
- Priority: at most one event is acted on per cycle, in the order c > u > d > l > r. Lower-priority events arriving in the same cycle are discarded, not queued.
- Latency: FSM outputs update on the clock edge after the press-event cycle, so a raw press held stable gives an output change DEBOUNCE+1 edges after the raw edge.
- FSM:
  - CLOSED (toggle_menu = 0):
    - c → MAIN, select_wave ← 0.
    - All other buttons are ignored.
  - MAIN (toggle_menu = 1):
    - u: select_wave − 1, wrapping 0 → 3.
    - d: select_wave + 1, wrapping 3 → 0.
    - c with select_wave 0..2: wave_mode ← select_wave, then → CLOSED.
    - c with select_wave = 3 → COLOR, select_color ← 0.
    - l/r with select_wave = 3: GRAPH_STATE −1 / +1, wrapping between 0 and NUM_GRAPHS-1.
    - l/r on any other line are ignored.
  - COLOR (toggle_menu = 2):
    - u/d step select_color over 0..2, wrapping 0 ↔ 2.
    - l/r drive left/right high for exactly one cycle (the output-update cycle).
    - c → MAIN with select_wave unchanged (stays 3).
- left and right are 0 in every state except the COLOR pulse cycle, and are never high simultaneously.
- Idle timeout:
  - The counter clears on any accepted event and on entry to any state.
  - It increments each cycle in MAIN or COLOR and is held at 0 in CLOSED.
  - When it reaches TIMEOUT-1: → CLOSED. select_wave, select_color, GRAPH_STATE and wave_mode keep their values.
  - If an accepted event and the timeout fall in the same cycle, the event wins and the counter clears.
- GRAPH_STATE and wave_mode persist across menu open/close cycles.
- Width rule: GRAPH_STATE arithmetic is done in 5 bits with explicit wrap compares against NUM_GRAPHS-1, never natural overflow.

Test Plan:
- Reset, then 2-cycle glitch on btn_c (DEBOUNCE = 4) → toggle_menu stays 0; hold btn_c 6 cycles → toggle_menu = 1 exactly 5 edges after the raw rise, select_wave = 0.
- In MAIN, press u once → select_wave = 3; press d twice → 1; press c → wave_mode = 1, toggle_menu = 0.
- MAIN with select_wave = 3, GRAPH_STATE = 19 (NUM_GRAPHS = 20): press r → 0; press l → 19; press l while select_wave = 0 → unchanged.
- COLOR: press r → right high for exactly one cycle, left = 0; press d three times → select_color 1, 2, 0; press c → toggle_menu = 1, select_wave = 3.
- btn_c and btn_u debounce in the same cycle while in MAIN → only c acted on; btn_u held continuously → no second event.
- Open menu, idle TIMEOUT cycles → toggle_menu = 0, GRAPH_STATE kept; assert reset_n low mid-COLOR → all outputs 0 asynchronously, before the next clock edge.
